// File: rtl/tlv493_frame_parser.sv
// Collects the 7-byte TLV493D read frame into one decoded, sign-extended sample with frame-counter checking.
// Sample appears one edge after the 7th byte; one-deep output register, an unread sample is overwritten (overrun flagged).
module tlv493_frame_parser #(
  parameter int OUT_WIDTH     = 16,
  parameter bit CHECK_CHANNEL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 frame_abort,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic [OUT_WIDTH-1:0] mag_x,
  output logic [OUT_WIDTH-1:0] mag_y,
  output logic [OUT_WIDTH-1:0] mag_z,
  output logic [11:0]          temp,
  output logic [1:0]           frm,
  output logic [1:0]           ch,
  output logic [2:0]           flags,
  output logic [2:0]           sample_status,
  output logic                 resync_req,
  output logic [15:0]          error_count,
  input  logic                 err_clear
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUBLISH} state_t;

  state_t r_state, w_state_nxt;
  logic [7:0] r_b [0:6];
  logic [2:0] r_idx, w_idx_nxt;
  logic       r_frame_done, r_long_seen;
  logic       r_frm_locked;
  logic [1:0] r_frm_exp;

  logic       w_store;
  logic [2:0] w_store_idx;
  logic       w_publish, w_seq_err, w_done_set, w_done_clr, w_long_set;

  logic [OUT_WIDTH-1:0] r_mag_x, r_mag_y, r_mag_z;
  logic [11:0] r_temp;
  logic [1:0]  r_frm, r_ch;
  logic [2:0]  r_flags, r_status;
  logic        r_sample_valid, r_resync;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Abort always wins; a start (with or without a byte) restarts collection at b0.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_store     = 1'b0;
    w_store_idx = 3'd0;
    w_publish   = 1'b0;
    w_seq_err   = 1'b0;
    w_done_set  = 1'b0;
    w_done_clr  = 1'b0;
    w_long_set  = 1'b0;
    case (r_state)
      S_IDLE, S_PUBLISH: begin
        w_publish   = (r_state == S_PUBLISH);
        w_state_nxt = S_IDLE;
        if (frame_abort) begin
          w_seq_err  = 1'b1;
          w_done_clr = 1'b1;
        end else if (frame_start) begin
          w_state_nxt = S_COLLECT;
          w_done_clr  = 1'b1;
          w_store     = byte_valid;
          w_idx_nxt   = byte_valid ? 3'd1 : 3'd0;
        end else if (byte_valid) begin
          // After a completed frame, trailing bytes are one long-frame error.
          if (!r_frame_done) begin
            w_seq_err = 1'b1;
          end else if (!r_long_seen) begin
            w_seq_err  = 1'b1;
            w_long_set = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (frame_abort) begin
          w_seq_err   = 1'b1;
          w_done_clr  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (frame_start) begin
          w_seq_err = (r_idx != 3'd0);
          w_store   = byte_valid;
          w_idx_nxt = byte_valid ? 3'd1 : 3'd0;
        end else if (byte_valid) begin
          w_store     = 1'b1;
          w_store_idx = r_idx;
          if (r_idx == 3'd6) begin
            w_idx_nxt   = 3'd0;
            w_done_set  = 1'b1;
            w_state_nxt = S_PUBLISH;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) r_b[i] <= '0;
      r_frame_done <= 1'b0;
      r_long_seen  <= 1'b0;
    end else begin
      if (w_store) r_b[w_store_idx] <= byte_data;
      if (w_done_clr) r_frame_done <= 1'b0;
      else if (w_done_set) r_frame_done <= 1'b1;
      if (w_done_set) r_long_seen <= 1'b0;
      else if (w_long_set) r_long_seen <= 1'b1;
    end
  end

  logic signed [11:0] w_bx, w_by, w_bz;
  logic [1:0] w_frm, w_ch;
  logic       w_frm_err, w_ch_err, w_err_evt;

  assign w_bx      = {r_b[0], r_b[4][7:4]};
  assign w_by      = {r_b[1], r_b[4][3:0]};
  assign w_bz      = {r_b[2], r_b[5][3:0]};
  assign w_frm     = r_b[3][3:2];
  assign w_ch      = r_b[3][1:0];
  assign w_frm_err = w_publish && r_frm_locked && (w_frm != r_frm_exp);
  assign w_ch_err  = (CHECK_CHANNEL != 1'b0) && (w_ch != 2'd0);
  assign w_err_evt = w_seq_err || w_frm_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frm_locked <= 1'b0;
      r_frm_exp    <= 2'd0;
    end else if (w_publish) begin
      if (!r_frm_locked) begin
        r_frm_locked <= 1'b1;
        r_frm_exp    <= w_frm + 2'd1;
      end else if (w_frm == r_frm_exp) begin
        r_frm_exp <= r_frm_exp + 2'd1;
      end else begin
        r_frm_locked <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mag_x        <= '0;
      r_mag_y        <= '0;
      r_mag_z        <= '0;
      r_temp         <= '0;
      r_frm          <= '0;
      r_ch           <= '0;
      r_flags        <= '0;
      r_status       <= '0;
      r_sample_valid <= 1'b0;
      r_resync       <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      r_resync <= w_frm_err;
      if (w_publish) begin
        r_mag_x        <= OUT_WIDTH'(w_bx);
        r_mag_y        <= OUT_WIDTH'(w_by);
        r_mag_z        <= OUT_WIDTH'(w_bz);
        r_temp         <= {r_b[3][7:4], r_b[6]};
        r_frm          <= w_frm;
        r_ch           <= w_ch;
        r_flags        <= r_b[5][6:4];
        r_status       <= {w_frm_err, w_ch_err, r_sample_valid && !sample_ready};
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end
      if (err_clear) r_err_cnt <= '0;
      else if (w_err_evt && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign mag_x         = r_mag_x;
  assign mag_y         = r_mag_y;
  assign mag_z         = r_mag_z;
  assign temp          = r_temp;
  assign frm           = r_frm;
  assign ch            = r_ch;
  assign flags         = r_flags;
  assign sample_status = r_status;
  assign sample_valid  = r_sample_valid;
  assign resync_req    = r_resync;
  assign error_count   = r_err_cnt;

endmodule

// File: tb/tb_tlv493_frame_parser.sv
// Table-driven frames with a sample scoreboard, plus sequences for overrun, short/long/aborted frames and reset.
module tb_tlv493_frame_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0, frame_abort = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        sample_ready = 1'b0, err_clear = 1'b0;
  logic        sample_valid, resync_req;
  logic [15:0] mag_x, mag_y, mag_z, error_count;
  logic [11:0] temp;
  logic [1:0]  frm, ch;
  logic [2:0]  flags, sample_status;

  always #5 clock = ~clock;

  tlv493_frame_parser #(.OUT_WIDTH(16), .CHECK_CHANNEL(1'b1)) dut (
    .clock(clock), .reset(reset),
    .frame_start(frame_start), .frame_abort(frame_abort),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .temp(temp), .frm(frm), .ch(ch), .flags(flags),
    .sample_status(sample_status), .resync_req(resync_req),
    .error_count(error_count), .err_clear(err_clear)
  );

  typedef struct {
    logic [55:0] frame;
    logic [69:0] exp;
    logic        rs;
    logic [15:0] ec;
  } vec_t;

  vec_t        tbl [6];
  logic [69:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [69:0] w_act;

  assign w_act = {mag_x, mag_y, mag_z, temp, frm, ch, flags, sample_status};

  function automatic logic [69:0] pk(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                     input logic [11:0] t, input logic [1:0] f, input logic [1:0] c,
                                     input logic [2:0] fl, input logic [2:0] st);
    return {x, y, z, t, f, c, fl, st};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      frame_start = (i == 0);
      byte_valid  = 1'b1;
      byte_data   = f[71-8*i -: 8];
    end
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 50) begin
      tick(1);
      k++;
    end
    check(name, 70'(sb_q.size()), 70'h0);
  endtask

  always @(negedge clock) begin
    if (!reset && sample_valid && sample_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no sample", w_act);
      end else begin
        check("sb_sample", w_act, sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{56'h12_80_FF_34_A7_53_9C, pk(16'h012A, 16'hF807, 16'hFFF3, 12'h39C, 2'd1, 2'd0, 3'b101, 3'b000), 1'b0, 16'd0};
    tbl[1] = '{56'h7F_00_80_08_F0_0F_00, pk(16'h07FF, 16'h0000, 16'hF80F, 12'h000, 2'd2, 2'd0, 3'b000, 3'b000), 1'b0, 16'd0};
    tbl[2] = '{56'hFF_FF_00_FC_FF_70_FF, pk(16'hFFFF, 16'hFFFF, 16'h0000, 12'hFFF, 2'd3, 2'd0, 3'b111, 3'b000), 1'b0, 16'd0};
    tbl[3] = '{56'h80_01_55_52_08_2A_11, pk(16'hF800, 16'h0018, 16'h055A, 12'h511, 2'd0, 2'd2, 3'b010, 3'b010), 1'b0, 16'd0};
    tbl[4] = '{56'h01_02_03_08_45_46_07, pk(16'h0014, 16'h0025, 16'h0036, 12'h007, 2'd2, 2'd0, 3'b100, 3'b100), 1'b1, 16'd1};
    tbl[5] = '{56'hAB_CD_EF_30_12_34_56, pk(16'hFAB1, 16'hFCD2, 16'hFEF4, 12'h356, 2'd0, 2'd0, 3'b011, 3'b000), 1'b0, 16'd1};

    tick(3);
    check("rst_outputs", w_act, 70'h0);
    check("rst_ctrl", 70'({sample_valid, resync_req, error_count}), 70'h0);
    reset = 1'b0;
    tick(2);

    // Decode and frame-counter sequence 1,2,3,0 then 2 (break), then 0 (relock).
    sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(tbl[i].exp);
      send({tbl[i].frame, 16'h0}, 7);
      check($sformatf("lat_pre%0d", i), 70'(sample_valid), 70'h0);
      tick(1);
      check($sformatf("lat_vld%0d", i), 70'(sample_valid), 70'h1);
      check($sformatf("resync%0d", i), 70'(resync_req), 70'(tbl[i].rs));
      tick(1);
      check($sformatf("resync_pulse%0d", i), 70'(resync_req), 70'h0);
      check($sformatf("err_cnt%0d", i), 70'(error_count), 70'(tbl[i].ec));
      drain($sformatf("drain%0d", i));
    end

    // Overrun: second sample replaces an unread first one.
    sample_ready = 1'b0;
    send({tbl[0].frame, 16'h0}, 7);
    tick(1);
    check("ovr_first", 70'({sample_valid, sample_status}), 70'(4'b1000));
    sb_q.push_back(pk(16'h07FF, 16'h0000, 16'hF80F, 12'h000, 2'd2, 2'd0, 3'b000, 3'b001));
    send({tbl[1].frame, 16'h0}, 7);
    tick(1);
    check("ovr_second", 70'({sample_valid, sample_status}), 70'(4'b1001));
    sample_ready = 1'b1;
    tick(1);
    check("xfer_clear", 70'(sample_valid), 70'h0);
    drain("drain_ovr");

    // Short frame followed by a complete one.
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check("clr", 70'(error_count), 70'h0);
    sb_q.push_back(tbl[2].exp);
    send({tbl[0].frame, 16'h0}, 3);
    send({tbl[2].frame, 16'h0}, 7);
    tick(1);
    check("short_cnt", 70'(error_count), 70'h1);
    drain("drain_short");

    // Long frame: two extra bytes count as one error.
    sb_q.push_back(tbl[3].exp);
    send({tbl[3].frame, 8'hEE, 8'hDD}, 9);
    tick(2);
    check("long_cnt", 70'(error_count), 70'h2);
    drain("drain_long");

    // Abort mid-frame together with err_clear, then stray bytes in IDLE.
    send({tbl[0].frame, 16'h0}, 2);
    frame_abort = 1'b1;
    err_clear   = 1'b1;
    tick(1);
    frame_abort = 1'b0;
    err_clear   = 1'b0;
    check("abort_clr", 70'(error_count), 70'h0);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    tick(3);
    byte_valid = 1'b0;
    tick(1);
    check("stray_cnt", 70'(error_count), 70'h3);
    check("abort_nosample", 70'(sample_valid), 70'h0);

    // Reset with a held sample and a frame in progress.
    sample_ready = 1'b0;
    send({tbl[0].frame, 16'h0}, 7);
    tick(1);
    check("pre_rst_vld", 70'(sample_valid), 70'h1);
    send({tbl[1].frame, 16'h0}, 3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_out", w_act, 70'h0);
    check("rst_async_ctrl", 70'({sample_valid, resync_req, error_count}), 70'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    sample_ready = 1'b1;
    sb_q.push_back(tbl[5].exp);
    send({tbl[5].frame, 16'h0}, 7);
    tick(1);
    check("post_rst_resync", 70'(resync_req), 70'h0);
    check("post_rst_cnt", 70'(error_count), 70'h0);
    drain("drain_post_rst");

    tick(5);
    check("sb_empty", 70'(sb_q.size()), 70'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
